// File: rtl/axi_ram_slave_pkg.sv
// Shared AXI definitions for the RAM slave: FSM state encoding and the only
// supported transfer size.
package axi_ram_slave_pkg;

  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdCap,
    StRdData,
    StWrData,
    StWrResp
  } state_e;

endpackage

// File: rtl/axi_ram_slave.sv
// Single-burst-at-a-time AXI slave bridging INCR bursts onto an external
// synchronous SRAM with one-cycle read latency.
module axi_ram_slave
  import axi_ram_slave_pkg::*;
#(
  parameter int unsigned SRAM_AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        axi_araddr,
  input  logic [3:0]         axi_arlen,
  input  logic [2:0]         axi_arsize,
  input  logic               axi_arvalid,
  output logic               axi_arready,
  output logic [31:0]        axi_rdata,
  output logic               axi_rlast,
  output logic               axi_rvalid,
  input  logic               axi_rready,
  input  logic [31:0]        axi_awaddr,
  input  logic [3:0]         axi_awlen,
  input  logic [2:0]         axi_awsize,
  input  logic               axi_awvalid,
  output logic               axi_awready,
  input  logic [31:0]        axi_wdata,
  input  logic [3:0]         axi_wstrb,
  input  logic               axi_wlast,
  input  logic               axi_wvalid,
  output logic               axi_wready,
  output logic               axi_bvalid,
  input  logic               axi_bready,
  output logic               sram_en,
  output logic [3:0]         sram_wen,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata,
  output logic               protocol_err
);

  state_e             r_state, w_state_nxt;
  logic [SRAM_AW-1:0] r_addr;
  logic [3:0]         r_len;
  logic [3:0]         r_cnt;
  logic [31:0]        r_rdata;
  logic               r_err;

  logic w_aw_hs, w_ar_hs, w_w_hs, w_r_hs, w_last;
  logic w_unused;

  assign w_unused = ^{axi_araddr, axi_awaddr};

  // Write wins over read in IDLE; readies are held low while reset is asserted.
  assign axi_awready = (r_state == StIdle) & ~rst;
  assign axi_arready = (r_state == StIdle) & ~rst & ~axi_awvalid;
  assign axi_wready  = (r_state == StWrData) & ~rst;

  assign w_aw_hs = axi_awvalid & axi_awready;
  assign w_ar_hs = axi_arvalid & axi_arready;
  assign w_w_hs  = axi_wvalid & axi_wready;
  assign w_r_hs  = (r_state == StRdData) & axi_rready;
  assign w_last  = (r_cnt == r_len);

  assign axi_rvalid   = (r_state == StRdData);
  assign axi_rlast    = (r_state == StRdData) & w_last;
  assign axi_rdata    = r_rdata;
  assign axi_bvalid   = (r_state == StWrResp);
  assign protocol_err = r_err;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_aw_hs) begin
          w_state_nxt = StWrData;
        end else if (w_ar_hs) begin
          w_state_nxt = StRdReq;
        end
      end
      StRdReq:  w_state_nxt = StRdCap;
      StRdCap:  w_state_nxt = StRdData;
      StRdData: if (axi_rready) w_state_nxt = w_last ? StIdle : StRdReq;
      StWrData: if (w_w_hs && w_last) w_state_nxt = StWrResp;
      StWrResp: if (axi_bready) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // SRAM is touched only in RD_REQ and on W handshakes; reset blocks a pending write.
  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = 4'b0000;
    sram_addr  = r_addr;
    sram_wdata = axi_wdata;
    if (!rst) begin
      if (r_state == StRdReq) begin
        sram_en = 1'b1;
      end else if (w_w_hs) begin
        sram_en  = 1'b1;
        sram_wen = axi_wstrb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_aw_hs) begin
        r_addr <= axi_awaddr[SRAM_AW+1:2];
        r_len  <= axi_awlen;
        r_cnt  <= '0;
      end else if (w_ar_hs) begin
        r_addr <= axi_araddr[SRAM_AW+1:2];
        r_len  <= axi_arlen;
        r_cnt  <= '0;
      end else if (w_w_hs || (w_r_hs && !w_last)) begin
        r_addr <= r_addr + SRAM_AW'(1);
        r_cnt  <= r_cnt + 4'd1;
      end
      if (r_state == StRdCap) begin
        r_rdata <= sram_rdata;
      end
      if ((w_aw_hs && (axi_awsize != SIZE_4B)) || (w_ar_hs && (axi_arsize != SIZE_4B)) ||
          (w_w_hs && (axi_wlast != w_last))) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Scoreboard bench for axi_ram_slave: a behavioural SRAM, a word-array reference
// model, randomized bursts and directed corner cases.
module tb_axi_ram_slave;
  import axi_ram_slave_pkg::*;

  localparam int unsigned AW = 10;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   axi_araddr, axi_awaddr, axi_rdata, axi_wdata, sram_wdata;
  logic [31:0]   sram_rdata = '0;
  logic [3:0]    axi_arlen, axi_awlen, axi_wstrb, sram_wen;
  logic [2:0]    axi_arsize, axi_awsize;
  logic          axi_arvalid, axi_arready, axi_rlast, axi_rvalid, axi_rready;
  logic          axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic          axi_bvalid, axi_bready, sram_en, protocol_err;
  logic [AW-1:0] sram_addr;

  axi_ram_slave #(.SRAM_AW(AW)) u_dut (
    .clk(clk), .rst(rst),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: byte-enabled writes, read data one cycle after the request.
  logic [31:0] mem [WORDS];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
      mem_init <= 1'b1;
    end else if (sram_en) begin
      if (sram_wen == 4'b0000) begin
        sram_rdata <= mem[sram_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (sram_wen[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
      end
    end
  end

  logic [31:0] ref_mem [WORDS];
  logic [32:0] exp_r[$];
  int          b_pending = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          ar_cyc = 0;
  bit          lat_armed = 1'b0;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected R beats and B responses as the DUT presents them.
  always @(negedge clk) begin
    logic [32:0] e;
    if (lat_armed && axi_rvalid) begin
      chk("r_first_latency", 32'(cyc - ar_cyc), 32'd3);
      lat_armed = 1'b0;
    end
    if (axi_rvalid && axi_rready) begin
      if (exp_r.size() == 0) begin
        chk("r_unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = exp_r.pop_front();
        chk("r_data", axi_rdata, e[31:0]);
        chk("r_last", 32'(axi_rlast), 32'(e[32]));
      end
    end
    if (axi_bvalid && axi_bready) begin
      if (b_pending == 0) chk("b_unexpected", 32'd1, 32'd0);
      else begin
        b_pending--;
        chk("b_resp", 32'(axi_bvalid), 32'd1);
      end
    end
  end

  task automatic do_write(input int addr, input int len, input int early, input bit with_ar);
    bit hs;
    int word;
    int w;
    word = (addr >> 2) % WORDS;
    axi_awaddr = 32'(addr); axi_awlen = 4'(len); axi_awsize = SIZE_4B; axi_awvalid = 1'b1;
    if (with_ar) begin
      axi_araddr = 32'(addr); axi_arlen = 4'd0; axi_arsize = SIZE_4B; axi_arvalid = 1'b1;
    end
    hs = 1'b0;
    for (int t = 0; t < 50 && !hs; t++) begin
      @(negedge clk);
      hs = axi_awready;
      if (hs && with_ar) chk("ar_blocked_by_aw", 32'(axi_arready), 32'd0);
      @(posedge clk); #1;
    end
    axi_awvalid = 1'b0;
    if (!hs) begin
      chk("aw_timeout", 32'd1, 32'd0);
      return;
    end
    for (int i = 0; i <= len; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        axi_wvalid = 1'b0;
        @(posedge clk); #1;
      end
      axi_wvalid = 1'b1; axi_wdata = wd[i]; axi_wstrb = ws[i];
      axi_wlast = (early >= 0) ? (i == early) : (i == len);
      w = (word + i) % WORDS;
      hs = 1'b0;
      for (int t = 0; t < 50 && !hs; t++) begin
        @(negedge clk);
        hs = axi_wready;
        if (hs) begin
          chk("w_sram_en", 32'(sram_en), 32'd1);
          chk("w_sram_addr", 32'(sram_addr), 32'(w));
          chk("w_sram_wen", 32'(sram_wen), 32'(ws[i]));
          chk("w_sram_wdata", sram_wdata, wd[i]);
          for (int b = 0; b < 4; b++) if (ws[i][b]) ref_mem[w][8*b +: 8] = wd[i][8*b +: 8];
        end
        @(posedge clk); #1;
      end
      if (!hs) begin
        chk("w_timeout", 32'd1, 32'd0);
        axi_wvalid = 1'b0;
        return;
      end
    end
    axi_wvalid = 1'b0; axi_wlast = 1'b0;
    b_pending++;
    for (int t = 0; t < 100 && b_pending > 0; t++) begin
      axi_bready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    axi_bready = 1'b0;
    if (b_pending > 0) begin
      chk("b_timeout", 32'd1, 32'd0);
      b_pending = 0;
    end
  endtask

  // stall_beat < 0 gives random rready; otherwise rready is held low for
  // stall_len valid cycles on that beat and the held outputs are checked.
  task automatic do_read(input int addr, input int len, input int stall_beat, input int stall_len);
    bit hs;
    int word, beat, stalled;
    logic [31:0] hold_d;
    logic        hold_l;
    word = (addr >> 2) % WORDS;
    axi_araddr = 32'(addr); axi_arlen = 4'(len); axi_arsize = SIZE_4B; axi_arvalid = 1'b1;
    hs = 1'b0;
    for (int t = 0; t < 100 && !hs; t++) begin
      @(negedge clk);
      hs = axi_arready;
      if (hs) begin
        for (int i = 0; i <= len; i++) exp_r.push_back({(i == len), ref_mem[(word + i) % WORDS]});
        ar_cyc = cyc;
        lat_armed = 1'b1;
      end
      @(posedge clk); #1;
    end
    axi_arvalid = 1'b0;
    if (!hs) begin
      chk("ar_timeout", 32'd1, 32'd0);
      return;
    end
    beat = 0; stalled = 0; hold_d = '0; hold_l = 1'b0;
    for (int t = 0; t < 400 && beat <= len; t++) begin
      if (beat == stall_beat && stalled < stall_len) axi_rready = 1'b0;
      else if (stall_beat >= 0) axi_rready = 1'b1;
      else axi_rready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (beat == stall_beat && !axi_rready && axi_rvalid) begin
        chk("stall_no_sram_read", 32'(sram_en), 32'd0);
        if (stalled == 0) begin
          hold_d = axi_rdata; hold_l = axi_rlast;
        end else begin
          chk("stall_rdata", axi_rdata, hold_d);
          chk("stall_rlast", 32'(axi_rlast), 32'(hold_l));
        end
        stalled++;
      end
      if (axi_rvalid && axi_rready) beat++;
      @(posedge clk); #1;
    end
    axi_rready = 1'b0;
    if (beat <= len) begin
      chk("r_timeout", 32'd1, 32'd0);
      exp_r.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit hs;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
    rst = 1'b1;
    axi_araddr = '0; axi_arlen = '0; axi_arsize = SIZE_4B; axi_arvalid = 1'b0;
    axi_awaddr = '0; axi_awlen = '0; axi_awsize = SIZE_4B; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
    axi_rready = 1'b0; axi_bready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(axi_awready), 32'd0);
    chk("rst_arready", 32'(axi_arready), 32'd0);
    chk("rst_rvalid", 32'(axi_rvalid), 32'd0);
    chk("rst_rlast", 32'(axi_rlast), 32'd0);
    chk("rst_rdata", axi_rdata, 32'd0);
    chk("rst_bvalid", 32'(axi_bvalid), 32'd0);
    chk("rst_wready", 32'(axi_wready), 32'd0);
    chk("rst_sram_en", 32'(sram_en), 32'd0);
    chk("rst_sram_wen", 32'(sram_wen), 32'd0);
    chk("rst_protocol_err", 32'(protocol_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_awready", 32'(axi_awready), 32'd1);
    chk("idle_arready", 32'(axi_arready), 32'd1);
    @(posedge clk); #1;

    // Write then read back a 4-beat burst.
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    do_write(32'h40, 3, -1, 1'b0);
    do_read(32'h40, 3, -1, 0);

    // Simultaneous AW and AR: write goes first, read returns the new data.
    wd[0] = 32'hAAAA_AAAA; ws[0] = 4'hF;
    do_write(32'h80, 0, -1, 1'b1);
    do_read(32'h80, 0, -1, 0);

    // Back-pressure on the second beat.
    do_read(32'h40, 3, 1, 5);

    for (int n = 0; n < 24; n++) begin
      int a, l;
      a = int'($urandom_range(0, 4095));
      l = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          wd[i] = $urandom;
          ws[i] = 4'($urandom_range(0, 15));
        end
        do_write(a, l, -1, 1'b0);
      end else begin
        do_read(a, l, -1, 0);
      end
    end
    chk("err_clean_traffic", 32'(protocol_err), 32'd0);

    // Wrap from word 1023 to word 0 with half-word strobes.
    wd[0] = 32'h1234_5678; wd[1] = 32'h9ABC_DEF0; ws[0] = 4'b0011; ws[1] = 4'b0011;
    do_write(32'hFFC, 1, -1, 1'b0);
    chk("wrap_word1023_low", 32'(mem[1023][15:0]), 32'h5678);
    chk("wrap_word0_low", 32'(mem[0][15:0]), 32'hDEF0);
    do_read(32'hFFC, 1, -1, 0);
    chk("err_after_wrap", 32'(protocol_err), 32'd0);

    // wlast on the first beat of a 2-beat burst.
    wd[0] = 32'h0BAD_0001; wd[1] = 32'h0BAD_0002; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(32'h100, 1, 0, 1'b0);
    chk("err_wlast_early", 32'(protocol_err), 32'd1);

    // Reset after the first beat of an 8-beat write to word 0.
    for (int i = 0; i < 8; i++) wd[i] = 32'hC0DE_0000 + 32'(i);
    axi_awaddr = 32'h0; axi_awlen = 4'd7; axi_awsize = SIZE_4B; axi_awvalid = 1'b1;
    hs = 1'b0;
    for (int t = 0; t < 50 && !hs; t++) begin
      @(negedge clk); hs = axi_awready; @(posedge clk); #1;
    end
    axi_awvalid = 1'b0;
    chk("abort_aw_hs", 32'(hs), 32'd1);
    axi_wvalid = 1'b1; axi_wdata = wd[0]; axi_wstrb = 4'hF; axi_wlast = 1'b0;
    hs = 1'b0;
    for (int t = 0; t < 50 && !hs; t++) begin
      @(negedge clk); hs = axi_wready; @(posedge clk); #1;
    end
    chk("abort_w1_hs", 32'(hs), 32'd1);
    ref_mem[0] = wd[0];
    axi_wdata = wd[1];
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_sram_en", 32'(sram_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rvalid", 32'(axi_rvalid), 32'd0);
    chk("abort_rdata", axi_rdata, 32'd0);
    chk("abort_wready", 32'(axi_wready), 32'd0);
    chk("abort_protocol_err", 32'(protocol_err), 32'd0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("abort_no_sram_en", 32'(sram_en), 32'd0);
      chk("abort_no_bvalid", 32'(axi_bvalid), 32'd0);
    end
    @(posedge clk); #1;
    axi_wvalid = 1'b0;
    do_read(32'h0, 0, -1, 0);
    repeat (4) @(posedge clk);
    chk("r_queue_drained", 32'(exp_r.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_ram_slave.md
AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 SHALL have parameter SRAM_AW, default 10, giving the word-address width of the backing SRAM (1024 words, 4 KB).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have the AR ports: axi_araddr in 32; axi_arlen in 4; axi_arsize in 3; axi_arvalid in 1; axi_arready out 1.
REQ-005 SHALL have the R ports: axi_rdata out 32; axi_rlast out 1; axi_rvalid out 1; axi_rready in 1.
REQ-006 SHALL have the AW ports: axi_awaddr in 32; axi_awlen in 4; axi_awsize in 3; axi_awvalid in 1; axi_awready out 1.
REQ-007 SHALL have the W ports: axi_wdata in 32; axi_wstrb in 4; axi_wlast in 1; axi_wvalid in 1; axi_wready out 1.
REQ-008 SHALL have the B ports: axi_bvalid out 1; axi_bready in 1.
REQ-009 SHALL have the SRAM ports: sram_en out 1; sram_wen out 4 (byte write enables); sram_addr out SRAM_AW; sram_wdata out 32; sram_rdata in 32. sram_rdata is valid one cycle after a read with sram_en=1 and sram_wen=0.
REQ-010 SHALL have port protocol_err, out, 1: sticky error flag, cleared only by rst.

Function
REQ-011 SHALL implement the states IDLE, RD_REQ, RD_CAP, RD_DATA, WR_DATA and WR_RESP; only one burst is in flight at a time.
REQ-012 In IDLE: axi_awready=1; axi_arready=~axi_awvalid. Write wins when both valids are high in the same cycle, so a dirty write-back lands before the refill that follows it.
REQ-013 On an AW or AR handshake SHALL latch:
- word address = addr[SRAM_AW+1:2];
- len;
- beat counter = 0.
addr[1:0] is ignored.
REQ-014 Read timing is as follows.
- RD_REQ: sram_en=1, sram_wen=0, sram_addr=current address.
- RD_CAP: capture sram_rdata into axi_rdata register.
- RD_DATA: axi_rvalid=1, axi_rlast=(counter==len).
- First rvalid occurs 3 cycles after the AR handshake cycle.
REQ-015 In RD_DATA with axi_rready=0, SHALL hold axi_rvalid, axi_rdata and axi_rlast stable.
REQ-016 On an R handshake: if the beat was last, go to IDLE; otherwise increment the address and counter and go to RD_REQ. Each beat takes 3 cycles minimum.
REQ-017 In WR_DATA: axi_wready=1. On each W handshake drive, in the same cycle:
- sram_en=1;
- sram_wen=axi_wstrb;
- sram_addr=current address;
- sram_wdata=axi_wdata.
Then increment the address and counter. A beat with wstrb=0 still consumes a beat.
REQ-018 The write burst ends on the handshake where counter==len, then goes to WR_RESP. axi_wlast does not end the burst.
REQ-019 In WR_RESP: axi_bvalid=1 until axi_bready; then go to IDLE. axi_awready and axi_arready are 0 outside IDLE.
REQ-020 The address increment SHALL be INCR, modulo 2^SRAM_AW; it wraps silently from the top word to word 0.
REQ-021 SHALL set protocol_err when any of the following occurs:
- arsize or awsize is not 3'b010 at handshake; the transfer still proceeds as 4-byte;
- a W handshake has wlast != (counter==len).
REQ-022 sram_en SHALL be 0 in every state and cycle not listed in REQ-014/017.
REQ-023 No combinational path from axi_rready/axi_wvalid to any ready output other than REQ-012's awvalid->arready.

Reset
REQ-024 With rst=1 at a clock edge, SHALL go to IDLE with the following outputs at 0 the following cycle:
- axi_rvalid, axi_rlast, axi_rdata;
- axi_bvalid, axi_wready;
- sram_en, sram_wen;
- protocol_err.
REQ-025 Reset mid-burst SHALL abandon the burst: no further SRAM writes and no B response; data already written stays.
REQ-026 In IDLE during reset, axi_awready and axi_arready SHALL be 0.

Structure
REQ-027 The state encodings and the AXI size code 3'b010 (SIZE_4B) SHALL live in the shared AXI defines header used by the cache blocks.
REQ-028 SHALL be one module with no sub-modules. The SRAM is external; the bench instantiates the existing DATA block RAM or a behavioural model.

Verification
REQ-029 Write then read back:
- AW addr=0x0000_0040, len=3; W 0x11,0x22,0x33,0x44 with wstrb=F and wlast on beat 4 -> one bvalid.
- Then AR addr=0x40, len=3 -> rdata 0x11,0x22,0x33,0x44; rlast only on beat 4; first rvalid 3 cycles after the AR handshake.
REQ-030 Simultaneous AW(0x80,len0,0xAAAA_AAAA) and AR(0x80,len0) -> AW accepted first, arready=0 that cycle; the read returns 0xAAAA_AAAA.
REQ-031 Back-pressure: rready held low for 5 cycles on beat 2 of a len=3 read -> rvalid/rdata stable throughout; no SRAM read issued during the stall.
REQ-032 Wrap and strobes:
- AW addr=0xFFC (word 1023), len=1, wstrb=4'b0011, data 0x1234_5678 then 0x9ABC_DEF0 -> SRAM word 1023 low half=0x5678, then word 0 written.
- A wlast-early variant sets protocol_err=1.
REQ-033 rst asserted after beat 1 of a len=7 write -> no further sram_en, bvalid never rises, all outputs 0 next cycle; a following read of word 0 returns beat-1 data.
